// File: rtl/fib_sequencer.sv
// Fibonacci sequencer: walks a register file's two read ports and one write port
// to leave F(n) mod 2^DATA_WIDTH in register RES_DIR.
module fib_sequencer #(
    parameter int DIR_WIDTH  = 10,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 16,
    parameter int RA_DIR     = 1,
    parameter int RB_DIR     = 2,
    parameter int RES_DIR    = 5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  n_target,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  iter_count,
    output logic                  prf_write_en,
    output logic [DIR_WIDTH-1:0]  prf_write_dir,
    output logic [DATA_WIDTH-1:0] prf_write_data,
    output logic [DIR_WIDTH-1:0]  prf_read_dir1,
    output logic [DIR_WIDTH-1:0]  prf_read_dir2,
    input  logic [DATA_WIDTH-1:0] prf_read_data1,
    input  logic [DATA_WIDTH-1:0] prf_read_data2
);

    // state    | meaning
    // IDLE     | waiting for start
    // INIT_A   | RA <= 0
    // INIT_B   | RB <= 1, k <= 1
    // SUM      | RES <= RA + RB, k <= k+1
    // MOVE_A   | RA <= RB
    // MOVE_B   | RB <= RES
    // RESULT   | n < 2: RES <= RA or RB
    // DONE     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_INIT_A, S_INIT_B, S_SUM, S_MOVE_A, S_MOVE_B, S_RESULT, S_DONE
    } state_t;

    localparam logic [DIR_WIDTH-1:0] RA  = DIR_WIDTH'(RA_DIR);
    localparam logic [DIR_WIDTH-1:0] RB  = DIR_WIDTH'(RB_DIR);
    localparam logic [DIR_WIDTH-1:0] RES = DIR_WIDTH'(RES_DIR);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  n_lat;
    logic [CNT_WIDTH-1:0]  k_inc;
    logic [DATA_WIDTH:0]   sum_full;

    assign k_inc    = iter_count + CNT_WIDTH'(1);
    assign sum_full = {1'b0, prf_read_data1} + {1'b0, prf_read_data2};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = start ? S_INIT_A : S_IDLE;
            S_INIT_A: state_nxt = S_INIT_B;
            S_INIT_B: state_nxt = (n_lat < CNT_WIDTH'(2)) ? S_RESULT : S_SUM;
            S_SUM:    state_nxt = (k_inc == n_lat) ? S_DONE : S_MOVE_A;
            S_MOVE_A: state_nxt = S_MOVE_B;
            S_MOVE_B: state_nxt = S_SUM;
            S_RESULT: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Write data is the only path that is combinational on the read data.
    always_comb begin
        prf_write_data = '0;
        case (state)
            S_INIT_B:                     prf_write_data = DATA_WIDTH'(1);
            S_SUM:                        prf_write_data = sum_full[DATA_WIDTH-1:0];
            S_MOVE_A, S_MOVE_B, S_RESULT: prf_write_data = prf_read_data1;
            default:                      prf_write_data = '0;
        endcase
    end

    // Port controls are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            iter_count    <= '0;
            n_lat         <= '0;
            prf_write_en  <= 1'b0;
            prf_write_dir <= '0;
            prf_read_dir1 <= '0;
            prf_read_dir2 <= '0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != S_IDLE);
            done          <= (state_nxt == S_DONE);
            prf_write_en  <= 1'b0;
            prf_write_dir <= '0;
            prf_read_dir1 <= '0;
            prf_read_dir2 <= '0;
            case (state_nxt)
                S_INIT_A: begin
                    prf_write_en  <= 1'b1;
                    prf_write_dir <= RA;
                end
                S_INIT_B: begin
                    prf_write_en  <= 1'b1;
                    prf_write_dir <= RB;
                end
                S_SUM: begin
                    prf_write_en  <= 1'b1;
                    prf_write_dir <= RES;
                    prf_read_dir1 <= RA;
                    prf_read_dir2 <= RB;
                end
                S_MOVE_A: begin
                    prf_write_en  <= 1'b1;
                    prf_write_dir <= RA;
                    prf_read_dir1 <= RB;
                end
                S_MOVE_B: begin
                    prf_write_en  <= 1'b1;
                    prf_write_dir <= RB;
                    prf_read_dir1 <= RES;
                end
                S_RESULT: begin
                    prf_write_en  <= 1'b1;
                    prf_write_dir <= RES;
                    prf_read_dir1 <= (n_lat == '0) ? RA : RB;
                end
                default: ;
            endcase

            if (state == S_IDLE && start) begin
                n_lat    <= n_target;
                overflow <= 1'b0;
            end
            if (state == S_INIT_B) iter_count <= CNT_WIDTH'(1);
            if (state == S_SUM) begin
                iter_count <= k_inc;
                if (sum_full[DATA_WIDTH]) overflow <= 1'b1;
            end
            if (state == S_RESULT) iter_count <= n_lat;
        end
    end

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer: two instances (256-bit and 64-bit) each beside a
// behavioural register file, checked against an arithmetic Fibonacci model.
module tb_fib_sequencer;

    localparam int RA = 1, RB = 2, RES = 5;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, start_b = 1'b0;
    logic [15:0]   n_a = '0, n_b = '0;
    logic          busy_a, done_a, ovf_a, we_a;
    logic          busy_b, done_b, ovf_b, we_b;
    logic [15:0]   iter_a, iter_b;
    logic [9:0]    wdir_a, rdir1_a, rdir2_a, wdir_b, rdir1_b, rdir2_b;
    logic [255:0]  wd_a, rd1_a, rd2_a;
    logic [63:0]   wd_b, rd1_b, rd2_b;
    logic [255:0]  prf_a [0:1023];
    logic [63:0]   prf_b [0:1023];

    assign rd1_a = (rdir1_a == 0) ? '0 : prf_a[rdir1_a];
    assign rd2_a = (rdir2_a == 0) ? '0 : prf_a[rdir2_a];
    assign rd1_b = (rdir1_b == 0) ? '0 : prf_b[rdir1_b];
    assign rd2_b = (rdir2_b == 0) ? '0 : prf_b[rdir2_b];

    always @(posedge clk) begin
        if (we_a && wdir_a != 0) prf_a[wdir_a] <= wd_a;
        if (we_b && wdir_b != 0) prf_b[wdir_b] <= wd_b;
    end

    fib_sequencer dut (
        .clk(clk), .arst_n(arst_n), .start(start_a), .n_target(n_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .iter_count(iter_a),
        .prf_write_en(we_a), .prf_write_dir(wdir_a), .prf_write_data(wd_a),
        .prf_read_dir1(rdir1_a), .prf_read_dir2(rdir2_a),
        .prf_read_data1(rd1_a), .prf_read_data2(rd2_a)
    );

    fib_sequencer #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .arst_n(arst_n), .start(start_b), .n_target(n_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .iter_count(iter_b),
        .prf_write_en(we_b), .prf_write_dir(wdir_b), .prf_write_data(wd_b),
        .prf_read_dir1(rdir1_b), .prf_read_dir2(rdir2_b),
        .prf_read_data1(rd1_b), .prf_read_data2(rd2_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: iterate F(k-1)+F(k) at width w, flag any carry out of bit w.
    task automatic fib_model(input int n, input int w, output logic [255:0] f,
                             output logic [255:0] ra_e, output logic [255:0] rb_e,
                             output bit ov);
        logic [256:0] a, b, s, mask;
        mask = (257'd1 << w) - 257'd1;
        a = '0; b = 257'd1; ov = 0;
        ra_e = '0; rb_e = 256'd1;
        for (int k = 1; k < n; k++) begin
            ra_e = a[255:0]; rb_e = b[255:0];
            s = a + b;
            if (s[w]) ov = 1;
            a = b;
            b = s & mask;
        end
        f = (n == 0) ? '0 : b[255:0];
    endtask

    function automatic logic [255:0] prf_val(input bit use64, input int idx);
        return use64 ? {192'b0, prf_b[idx]} : prf_a[idx];
    endfunction

    task automatic run(input bit use64, input int n, input bit mid_pulse);
        int busy_cnt = 0, done_cnt = 0, wr_cnt = 0;
        bit finished = 0;
        int got_dirs[$];
        int exp_dirs[$];
        logic [255:0] f, ra_e, rb_e;
        bit ov;
        bit ob;
        fib_model(n, use64 ? 64 : 256, f, ra_e, rb_e, ov);
        @(negedge clk);
        if (use64) begin start_b = 1; n_b = 16'(n); end
        else begin start_a = 1; n_a = 16'(n); end
        @(negedge clk);
        start_a = 0; start_b = 0;
        n_a = 16'($urandom); n_b = 16'($urandom);
        for (int c = 0; c < 2000; c++) begin
            ob = use64 ? busy_b : busy_a;
            if (!ob) begin finished = 1; break; end
            busy_cnt++;
            if (busy_cnt == 1) chk("ovf_clear_at_start", use64 ? ovf_b : ovf_a, 0);
            if (use64 ? done_b : done_a) done_cnt++;
            if (use64 ? we_b : we_a) begin
                wr_cnt++;
                got_dirs.push_back(int'(use64 ? wdir_b : wdir_a));
            end
            if (mid_pulse) begin
                if (use64) start_b = (busy_cnt == 7); else start_a = (busy_cnt == 7);
            end
            @(negedge clk);
        end
        start_a = 0; start_b = 0;
        chk("run_terminates", finished, 1);
        exp_dirs.push_back(RA);
        exp_dirs.push_back(RB);
        if (n < 2) exp_dirs.push_back(RES);
        else for (int k = 1; k < n; k++) begin
            exp_dirs.push_back(RES);
            if (k < n - 1) begin exp_dirs.push_back(RA); exp_dirs.push_back(RB); end
        end
        chk("busy_cycles", busy_cnt, (n < 2) ? 4 : 3 * n - 2);
        chk("done_pulses", done_cnt, 1);
        chk("write_count", wr_cnt, exp_dirs.size());
        if (got_dirs.size() == exp_dirs.size())
            for (int i = 0; i < exp_dirs.size(); i++)
                if (got_dirs[i] != exp_dirs[i]) begin
                    chk("write_dir_seq", got_dirs[i], exp_dirs[i]);
                    break;
                end
        chk("fibb_out", prf_val(use64, RES), f);
        chk("ra_final", prf_val(use64, RA), ra_e);
        chk("rb_final", prf_val(use64, RB), rb_e);
        chk("overflow", use64 ? ovf_b : ovf_a, ov);
        chk("iter_count", use64 ? iter_b : iter_a, n);
        chk("done_low_idle", use64 ? done_b : done_a, 0);
    endtask

    initial begin
        logic [255:0] held;
        int last_done, ndone, gap;
        bit ok;

        #2;
        chk("rst_outputs_a", {busy_a, done_a, ovf_a, iter_a, we_a, wdir_a, rdir1_a, rdir2_a}, 0);
        chk("rst_wdata_a", wd_a, 0);
        chk("rst_outputs_b", {busy_b, done_b, ovf_b, iter_b, we_b, wdir_b, rdir1_b, rdir2_b}, 0);
        @(negedge clk);
        arst_n = 1;

        run(0, 0, 0);
        run(0, 1, 0);
        run(0, 2, 0);
        run(0, 5, 0);
        run(0, 10, 0);

        run(1, 93, 0);
        run(1, 94, 0);
        run(1, 3, 0);
        for (int i = 0; i < 3; i++) run(1, int'($urandom_range(80, 110)), 0);
        for (int i = 0; i < 6; i++) run(0, int'($urandom_range(0, 40)), 0);
        run(0, 370, 0);

        run(0, 20, 1);

        // Reset in the middle of a run.
        @(negedge clk);
        start_a = 1; n_a = 16'd20;
        @(negedge clk);
        start_a = 0;
        repeat (9) @(negedge clk);
        held = prf_a[RES];
        arst_n = 0;
        #1;
        chk("midrst_outputs", {busy_a, done_a, ovf_a, iter_a, we_a, wdir_a, rdir1_a, rdir2_a}, 0);
        chk("midrst_wdata", wd_a, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_write", we_a, 0);
        end
        chk("midrst_res_kept", prf_a[RES], held);
        arst_n = 1;
        @(negedge clk);
        chk("post_rst_idle", busy_a, 0);
        run(0, 3, 0);

        // start held high: back-to-back runs every 11 cycles.
        @(negedge clk);
        n_a = 16'd4; start_a = 1;
        last_done = -1; ndone = 0; ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_a) begin
                chk("held_fib", prf_a[RES], 3);
                if (last_done >= 0) begin
                    gap = c - last_done;
                    chk("held_done_gap", gap, 11);
                end
                last_done = c;
                ndone++;
                if (ndone == 3) begin start_a = 0; ok = 1; break; end
            end
        end
        start_a = 0;
        chk("held_three_runs", ok, 1);
        repeat (3) @(negedge clk);
        chk("held_back_idle", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fib_sequencer.md
Name: fib_sequencer

Overview:
FSM controller that drives the physical register file's two read ports and single write port to compute Fibonacci F(n). Operands live in two PRF registers, RA_DIR and RB_DIR. The result is written to RES_DIR, register 5 by default, which the PRF exposes on fibb_out. The controller sits beside the PRF and is the sole master of its write port while busy.

Parameters:
DIR_WIDTH, 10, PRF address width; must match the PRF.
DATA_WIDTH, 256, PRF data width; all arithmetic is modulo 2^DATA_WIDTH.
CNT_WIDTH, 16, width of n_target and iter_count.
RA_DIR, 1, PRF register holding F(k-1).
RB_DIR, 2, PRF register holding F(k).
RES_DIR, 5, PRF register receiving results.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
start  in  1  request a computation; sampled only in IDLE
n_target  in  CNT_WIDTH  index n; latched when start is accepted
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in DONE
overflow  out  1  sticky; set on carry-out of any SUM addition
iter_count  out  CNT_WIDTH  current k (index of F held in RB)
prf_write_en  out  1  PRF write enable
prf_write_dir  out  DIR_WIDTH  PRF write address
prf_write_data  out  DATA_WIDTH  PRF write data
prf_read_dir1  out  DIR_WIDTH  PRF read address 1
prf_read_dir2  out  DIR_WIDTH  PRF read address 2
prf_read_data1  in  DATA_WIDTH  PRF read data 1 (combinational in PRF)
prf_read_data2  in  DATA_WIDTH  PRF read data 2

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE.
  - busy, done, overflow, iter_count = 0.
  - n latch = 0.
  - All prf_* outputs = 0.
- Reset mid-operation aborts immediately and issues no further writes.
- PRF port outputs are decoded from state only (Moore). prf_write_data is the only output combinational on prf_read_data.
- In IDLE and DONE: prf_write_en = 0 and all PRF addresses/data = 0.
- RA_DIR, RB_DIR and RES_DIR must be nonzero and distinct. Register 0 reads as zero.
- States:
  - IDLE: if start, latch n <= n_target, clear overflow, go INIT_A. Otherwise stay.
  - INIT_A: write RA_DIR <= 0. Go INIT_B.
  - INIT_B: write RB_DIR <= 1; k <= 1. If n < 2 go RESULT, else go SUM.
  - SUM: read1 = RA_DIR, read2 = RB_DIR; write RES_DIR <= read1 + read2 (truncated to DATA_WIDTH).
    - If carry-out, set overflow.
    - k <= k+1.
    - If k+1 == n go DONE, else go MOVE_A.
  - MOVE_A: read1 = RB_DIR; write RA_DIR <= read1. Go MOVE_B.
  - MOVE_B: read1 = RES_DIR; write RB_DIR <= read1. Go SUM.
  - RESULT (n < 2 only): read1 = RA_DIR if n == 0, else RB_DIR; write RES_DIR <= read1; k <= n. Go DONE.
  - DONE: done = 1 for this cycle only. Go IDLE.
- Latency (cycles with busy high, from the cycle after start is accepted):
  - n < 2: 4.
  - n >= 2: 3n-2.
- RES_DIR holds F(n) mod 2^DATA_WIDTH from the cycle after the last write onward.
- start while busy, including in DONE, is ignored. It is not queued.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.
- n_target changes after acceptance have no effect.
- iter_count wraps only if n > 2^CNT_WIDTH-1, which cannot occur.
- overflow stays set until the next accepted start.

Test Plan:
1. Reset, start with n=0 -> busy high 4 cycles, done pulses once, fibb_out = 0, iter_count = 0. Repeat with n=1 -> fibb_out = 1, iter_count = 1.
2. n=2 -> 4 busy cycles, fibb_out = 1. n=5 -> 13 busy cycles, fibb_out = 5, RA_DIR = 2, RB_DIR = 3, overflow = 0.
3. n=10 -> 28 busy cycles, fibb_out = 55, iter_count = 10. Check prf_write_en pattern: 2 init writes, then SUM/MOVE_A/MOVE_B repeating, final SUM.
4. DATA_WIDTH=64:
   - n=93 -> fibb_out = 12200160415121876738, overflow = 0.
   - n=94 -> fibb_out = 1293530146158671551, overflow = 1.
   - Then n=3 -> overflow cleared at start, fibb_out = 2.
5. Start n=20; pulse start again mid-run -> ignored, result 6765 after 58 busy cycles. Then assert arst_n=0 at cycle 10 of a new n=20 run -> all outputs 0 immediately, no writes. Next start n=3 -> fibb_out = 2.
6. Hold start = 1 with n=4 for 3 runs -> done every 11 cycles (10 busy + 1 IDLE), fibb_out = 3 each run.
